// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding,
// wait-counter width and the freeze/flush priority resolver.
package pipeline_stall_ctrl_pkg;

    localparam int STALL_WAIT_CNT_LEN = 8;

    typedef enum logic [1:0] {
        STALL_ST_RUN      = 2'd0,
        STALL_ST_MEM_WAIT = 2'd1,
        STALL_ST_ERROR    = 2'd2
    } stall_state_e;

    typedef struct packed {
        logic pc_freeze;
        logic if_id_freeze;
        logic if_id_flush;
        logic id_exe_flush;
        logic back_freeze;
    } stall_ctrl_t;

    localparam int CNT_HAZARD = 0;
    localparam int CNT_MEM    = 1;
    localparam int CNT_FLUSH  = 2;
    localparam int NUM_CNT    = 3;

    // Memory stall beats branch flush, which beats the load-use hazard stall.
    function automatic stall_ctrl_t resolve_ctrl(input logic frz,
                                                 input logic branch,
                                                 input logic hazard);
        stall_ctrl_t c;
        c             = '0;
        c.back_freeze = frz;
        if (frz) begin
            c.pc_freeze    = 1'b1;
            c.if_id_freeze = 1'b1;
        end else if (branch) begin
            c.if_id_flush  = 1'b1;
            c.id_exe_flush = 1'b1;
        end else if (hazard) begin
            c.pc_freeze    = 1'b1;
            c.if_id_freeze = 1'b1;
            c.id_exe_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: memory-wait FSM with watchdog plus freeze/flush
// priority. Stall performance counters are built only when PERF_CNT_EN is defined.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             mem_start,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             back_freeze,
    output logic             mem_error,
    output logic [CNT_W-1:0] hazard_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [STALL_WAIT_CNT_LEN-1:0] WAIT_LIMIT =
        STALL_WAIT_CNT_LEN'(MEM_TIMEOUT - 1);

    stall_state_e                  state_q, state_d;
    logic [STALL_WAIT_CNT_LEN-1:0] wait_cnt_q, wait_cnt_d;
    logic                          mem_error_q, mem_error_d;
    logic                          frz;
    logic                          mem_req_v;
    stall_ctrl_t                   ctrl;

    // A request held across reset must not launch an access until reset is released.
    assign mem_req_v = mem_req & ~rst;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        mem_start   = 1'b0;
        frz         = 1'b0;
        unique case (state_q)
            STALL_ST_RUN: begin
                if (mem_req_v) begin
                    mem_start = 1'b1;
                    if (!mem_ready) begin
                        frz        = 1'b1;
                        state_d    = STALL_ST_MEM_WAIT;
                        wait_cnt_d = '0;
                    end
                end
            end
            STALL_ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = STALL_ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    frz = 1'b1;
                    if (wait_cnt_q == WAIT_LIMIT) begin
                        state_d     = STALL_ST_ERROR;
                        wait_cnt_d  = '0;
                        mem_error_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            STALL_ST_ERROR: begin
                frz         = 1'b1;
                mem_error_d = 1'b1;
            end
            default: begin
                state_d    = STALL_ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= STALL_ST_RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign ctrl         = resolve_ctrl(frz, branch_taken, hazard_detected);
    assign pc_freeze    = ctrl.pc_freeze;
    assign if_id_freeze = ctrl.if_id_freeze;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_exe_flush = ctrl.id_exe_flush;
    assign back_freeze  = ctrl.back_freeze;
    assign mem_error    = mem_error_q;

`ifdef PERF_CNT_EN
    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0]   cnt_val [NUM_CNT];

    // A hazard stall is the only case that freezes PC while inserting a bubble.
    assign cnt_inc[CNT_HAZARD] = ctrl.pc_freeze & ctrl.id_exe_flush;
    assign cnt_inc[CNT_MEM]    = ctrl.back_freeze;
    assign cnt_inc[CNT_FLUSH]  = ctrl.if_id_flush;

    genvar gi;
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        sat_counter #(
            .WIDTH(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (cnt_inc[gi]),
            .count(cnt_val[gi])
        );
    end

    assign hazard_stall_cnt = cnt_val[CNT_HAZARD];
    assign mem_stall_cnt    = cnt_val[CNT_MEM];
    assign flush_cnt        = cnt_val[CNT_FLUSH];
`else
    assign hazard_stall_cnt = '0;
    assign mem_stall_cnt    = '0;
    assign flush_cnt        = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4); counter
// expectations follow PERF_CNT_EN.
module tb_pipeline_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hazard_detected = 1'b0;
    logic       branch_taken = 1'b0;
    logic       mem_req = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_start, pc_freeze, if_id_freeze, if_id_flush;
    logic       id_exe_flush, back_freeze, mem_error;
    logic [3:0] hazard_stall_cnt, mem_stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .mem_start       (mem_start),
        .pc_freeze       (pc_freeze),
        .if_id_freeze    (if_id_freeze),
        .if_id_flush     (if_id_flush),
        .id_exe_flush    (id_exe_flush),
        .back_freeze     (back_freeze),
        .mem_error       (mem_error),
        .hazard_stall_cnt(hazard_stall_cnt),
        .mem_stall_cnt   (mem_stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    // Expected controls {mem_start, pc_frz, ifid_frz, ifid_flush, idexe_flush, back_frz, mem_error}
    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_HAZ  = 7'b0110100;
    localparam logic [6:0] C_BR   = 7'b0001100;
    localparam logic [6:0] C_ZW   = 7'b1000000;
    localparam logic [6:0] C_ST   = 7'b1110010;
    localparam logic [6:0] C_WT   = 7'b0110010;
    localparam logic [6:0] C_ERR  = 7'b0110011;

    typedef struct {
        int         idx;
        logic [6:0] ctl;
        logic [3:0] c_hz;
        logic [3:0] c_mem;
        logic [3:0] c_fl;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         failures = 0;
    int         vec_n = 0;
    logic [3:0] m_hz = 4'd0, m_mem = 4'd0, m_fl = 4'd0;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic en);
        return (en && v != 4'hF) ? v + 4'd1 : v;
    endfunction

    // in = {hazard_detected, branch_taken, mem_req, mem_ready}
    task automatic step(input logic r, input logic [3:0] in, input logic [6:0] ctl);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        {hazard_detected, branch_taken, mem_req, mem_ready} = in;
        if (r) begin
            m_hz = 4'd0;
            m_mem = 4'd0;
            m_fl = 4'd0;
        end
        e.idx = vec_n;
        e.ctl = ctl;
`ifdef PERF_CNT_EN
        e.c_hz = m_hz;
        e.c_mem = m_mem;
        e.c_fl = m_fl;
`else
        e.c_hz = 4'd0;
        e.c_mem = 4'd0;
        e.c_fl = 4'd0;
`endif
        sb_q.push_back(e);
        vec_n++;
        if (!r) begin
            m_hz = sat_inc(m_hz, ctl[5] & ctl[2]);
            m_mem = sat_inc(m_mem, ctl[1]);
            m_fl = sat_inc(m_fl, ctl[3]);
        end
    endtask

    initial begin : monitor
        exp_t       e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act = {mem_start, pc_freeze, if_id_freeze, if_id_flush,
                       id_exe_flush, back_freeze, mem_error};
                checks++;
                if (act !== e.ctl) begin
                    failures++;
                    $display("FAIL ctl vec=%0d actual=%b required=%b", e.idx, act, e.ctl);
                end
                checks++;
                if ({hazard_stall_cnt, mem_stall_cnt, flush_cnt} !== {e.c_hz, e.c_mem, e.c_fl}) begin
                    failures++;
                    $display("FAIL cnt vec=%0d actual=hz%0d/mem%0d/fl%0d required=hz%0d/mem%0d/fl%0d",
                             e.idx, hazard_stall_cnt, mem_stall_cnt, flush_cnt,
                             e.c_hz, e.c_mem, e.c_fl);
                end
                $display("vec %0d ctl=%b cnt=%0d/%0d/%0d", e.idx, act,
                         hazard_stall_cnt, mem_stall_cnt, flush_cnt);
            end
        end
    end

    initial begin : stimulus
        // Reset state and idle, then a two-cycle hazard stall
        step(1'b1, 4'b0000, C_IDLE);
        step(1'b0, 4'b0000, C_IDLE);
        step(1'b0, 4'b1000, C_HAZ);
        step(1'b0, 4'b1000, C_HAZ);
        step(1'b0, 4'b0000, C_IDLE);

        // Zero-wait accesses, back to back, stay in RUN
        step(1'b1, 4'b0000, C_IDLE);
        step(1'b0, 4'b0011, C_ZW);
        step(1'b0, 4'b0011, C_ZW);
        step(1'b0, 4'b0000, C_IDLE);

        // Ready after three cycles, then a new access right after release
        step(1'b1, 4'b0000, C_IDLE);
        step(1'b0, 4'b0010, C_ST);
        step(1'b0, 4'b0010, C_WT);
        step(1'b0, 4'b0010, C_WT);
        step(1'b0, 4'b0011, C_IDLE);
        step(1'b0, 4'b0011, C_ZW);
        step(1'b0, 4'b0000, C_IDLE);

        // Branch beats hazard; then the same pair held during a memory stall
        step(1'b1, 4'b0000, C_IDLE);
        step(1'b0, 4'b1100, C_BR);
        step(1'b0, 4'b0000, C_IDLE);
        step(1'b1, 4'b0000, C_IDLE);
        step(1'b0, 4'b0010, C_ST);
        step(1'b0, 4'b1110, C_WT);
        step(1'b0, 4'b1110, C_WT);
        step(1'b0, 4'b1111, C_BR);
        step(1'b0, 4'b0000, C_IDLE);

        // Ready on the last allowed wait cycle wins over the watchdog
        step(1'b1, 4'b0000, C_IDLE);
        step(1'b0, 4'b0010, C_ST);
        step(1'b0, 4'b0010, C_WT);
        step(1'b0, 4'b0010, C_WT);
        step(1'b0, 4'b0010, C_WT);
        step(1'b0, 4'b0011, C_IDLE);
        step(1'b0, 4'b0011, C_ZW);

        // Watchdog timeout, sticky ERROR, reset out of it
        step(1'b1, 4'b0000, C_IDLE);
        step(1'b0, 4'b0010, C_ST);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0010, C_WT);
        step(1'b0, 4'b0000, C_ERR);
        step(1'b0, 4'b1111, C_ERR);
        step(1'b0, 4'b0010, C_ERR);
        step(1'b1, 4'b0000, C_IDLE);
        step(1'b0, 4'b0000, C_IDLE);
        step(1'b0, 4'b0010, C_ST);

        // Reset mid-wait with the request still held
        step(1'b0, 4'b0010, C_WT);
        step(1'b1, 4'b0010, C_IDLE);
        step(1'b0, 4'b0010, C_ST);
        step(1'b0, 4'b0011, C_IDLE);

        // Saturation of the 4-bit hazard counter
        step(1'b1, 4'b0000, C_IDLE);
        for (int i = 0; i < 20; i++) step(1'b0, 4'b1000, C_HAZ);
        step(1'b0, 4'b0000, C_IDLE);
        step(1'b0, 4'b0000, C_IDLE);

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges three stall sources: the load-use/no-forward hazard flag from the ID-stage hazard unit, the EXE-stage branch-taken flush, and a variable-latency data-memory handshake in MEM. It drives every pipeline-register freeze and flush control. It owns the memory-wait FSM, including a watchdog timeout, and optional stall performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 255 — max cycles in MEM_WAIT before declaring error (1..255)
- CNT_W, 32 — performance counter width

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- hazard_detected  input  1  ID-stage hazard flag from hazard unit
- branch_taken  input  1  EXE-stage branch resolved taken
- mem_req  input  1  MEM-stage instruction is load/store (MEM_R_EN | MEM_W_EN)
- mem_ready  input  1  data memory completes the current access this cycle
- mem_start  output  1  one-cycle access-launch pulse to memory controller
- pc_freeze  output  1  hold PC
- if_id_freeze  output  1  hold IF/ID register
- if_id_flush  output  1  clear IF/ID to NOP
- id_exe_flush  output  1  clear ID/EXE to bubble
- back_freeze  output  1  hold ID/EXE, EXE/MEM, MEM/WB registers
- mem_error  output  1  sticky watchdog error
- hazard_stall_cnt, mem_stall_cnt, flush_cnt  output  CNT_W  stall/flush counts

## Operation
- FSM states: RUN, MEM_WAIT, ERROR.
- RUN:
  - mem_req=1 → mem_start=1.
  - If mem_ready=1 in the same cycle: zero-wait, stay in RUN.
  - Else → MEM_WAIT, with back_freeze=1 this cycle.
- MEM_WAIT:
  - mem_start=0.
  - back_freeze = !mem_ready.
  - mem_ready=1 → RUN. The pipeline advances on that edge.
  - Wait counter increments each cycle without ready. Reaching MEM_TIMEOUT → ERROR.
- ERROR:
  - back_freeze=pc_freeze=if_id_freeze=1, mem_error=1.
  - Only rst exits.
- Derived frz = back_freeze (memory stall in progress).
- Priority: memory stall > branch flush > hazard stall.
  - frz=1: pc_freeze=if_id_freeze=1, both flushes 0. branch_taken stays held in the frozen EXE stage and is applied after release.
  - frz=0, branch_taken=1: if_id_flush=id_exe_flush=1, pc_freeze=if_id_freeze=0 (PC loads target). hazard_detected is ignored because the ID instruction is squashed.
  - frz=0, branch_taken=0, hazard_detected=1: pc_freeze=if_id_freeze=1, id_exe_flush=1 (bubble), if_id_flush=0.
  - Otherwise all controls 0.
- Counters:
  - hazard_stall_cnt +1 per hazard-stall cycle.
  - mem_stall_cnt +1 per cycle with back_freeze=1 (ERROR included).
  - flush_cnt +1 per branch-flush cycle.
  - All counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- All control outputs are combinational from state and inputs (Mealy). Only state, the wait counter, mem_error and the perf counters are registered.
- mem_start is asserted exactly one cycle per access: the first cycle the instruction sits in MEM in RUN.
- Wait counter: 8 bits. Cleared on entry to MEM_WAIT and on leaving it.
  - ERROR is entered on the edge after the MEM_TIMEOUT-th consecutive non-ready MEM_WAIT cycle.
  - mem_ready arriving on that same cycle wins: the FSM goes to RUN.
- Reset values (async, immediate): state=RUN, wait counter=0, mem_error=0, all counters=0. All control outputs evaluate to 0 with inputs low.
- Reset asserted mid-MEM_WAIT or in ERROR forces RUN immediately. No mem_start is reissued until mem_req is seen in RUN after reset release.
- Back-to-back memory instructions: each gets its own mem_start in its first RUN cycle after the previous release.

## Configuration
- PERF_CNT_EN defined: the three saturating counters are built.
- PERF_CNT_EN undefined: counter logic is removed. Ports remain and are tied to 0.
- FSM behaviour is identical in both builds.

## Structure
- In defines.v, the shared constants file:
  - state encodings `STALL_ST_RUN`=2'd0, `STALL_ST_MEM_WAIT`=2'd1, `STALL_ST_ERROR`=2'd2
  - `STALL_WAIT_CNT_LEN`=8
- Sub-module sat_counter (params WIDTH; ports clk, rst, inc, count), instantiated three times under PERF_CNT_EN.

## Test plan
- Reset then idle inputs → all controls 0, counters 0. hazard_detected=1 for 2 cycles → pc_freeze=if_id_freeze=id_exe_flush=1 both cycles, hazard_stall_cnt=2.
- mem_req=1, mem_ready=1 same cycle → mem_start=1 for 1 cycle, back_freeze never 1, state stays RUN.
- mem_req=1, mem_ready after 3 cycles → mem_start 1 cycle. back_freeze=1 for 3 cycles and 0 in the ready cycle. mem_stall_cnt=3.
- branch_taken=1 with hazard_detected=1 → if_id_flush=id_exe_flush=1, pc_freeze=0. Same pair during MEM_WAIT → no flush until mem_ready, then flush one cycle, flush_cnt=1.
- MEM_TIMEOUT=4, mem_ready never → ERROR after 4 wait cycles, mem_error=1 sticky. rst pulse mid-ERROR → all outputs 0, state RUN.
- CNT_W=4 with PERF_CNT_EN, 20 hazard cycles → hazard_stall_cnt=15. Build without PERF_CNT_EN → counters read 0.
